// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store sequencer: access sizes,
// FSM states and fault cause codes.
package lsu_mem_ctrl_pkg;

  localparam int unsigned LSU_ADDR_W = 64;
  localparam int unsigned LSU_DATA_W = 64;

  typedef enum logic [1:0] {
    LSU_SIZE_B = 2'd0,
    LSU_SIZE_H = 2'd1,
    LSU_SIZE_W = 2'd2,
    LSU_SIZE_D = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'd0,
    LSU_ST_REQ  = 2'd1,
    LSU_ST_WAIT = 2'd2,
    LSU_ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  function automatic logic [3:0] lsu_cause(input logic is_store, input logic misalign);
    if (misalign) return is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    return is_store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus between the load/store sequencer (master) and memory (slave):
// valid/ready request channel plus an always-accepted response channel.
interface lsu_mem_ctrl_if #(
  parameter int unsigned ADDR_W = lsu_mem_ctrl_pkg::LSU_ADDR_W,
  parameter int unsigned DATA_W = lsu_mem_ctrl_pkg::LSU_DATA_W
);

  logic                bus_req_valid;
  logic                bus_req_ready;
  logic [ADDR_W-1:0]   bus_req_addr;
  logic                bus_req_wen;
  logic [DATA_W-1:0]   bus_req_wdata;
  logic [DATA_W/8-1:0] bus_req_wmask;
  logic                bus_resp_valid;
  logic [DATA_W-1:0]   bus_resp_rdata;
  logic                bus_resp_err;

  modport master (
    output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
  );

  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
  );

endinterface

// File: rtl/lsu_mem_ctrl_strb_gen.sv
// Combinational lane steering: size/offset -> unshifted byte enable, shifted
// write mask and write data, and a natural-alignment check.
module lsu_mem_ctrl_strb_gen
  import lsu_mem_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_W = LSU_DATA_W,
  localparam int unsigned LANES  = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(LANES)
) (
  input  lsu_size_e         size,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] wdata,
  output logic [LANES-1:0]  byte_enable,
  output logic [LANES-1:0]  wmask,
  output logic [DATA_W-1:0] wdata_sh,
  output logic              misaligned
);

  int unsigned      n_bytes;
  logic [OFF_W-1:0] low_mask;

  always_comb begin
    n_bytes     = 32'd1 << size;
    byte_enable = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      byte_enable[i] = (i < n_bytes);
    end
    low_mask   = OFF_W'(n_bytes - 32'd1);
    misaligned = |(offset & low_mask);
    // Lanes shifted past the top of the word are dropped, not wrapped.
    wmask      = byte_enable << offset;
    wdata_sh   = wdata << {offset, 3'b000};
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between MEM stage and data-memory bus, one access in flight.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned accesses without a bus request.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = LSU_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [1:0]          ex_size,
  input  logic                flush,
  output logic                mem_stall,
  output logic                lsu_done,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [DATA_W/8-1:0] lsu_byte_enable,
  output logic                lsu_fault,
  output logic [3:0]          lsu_fault_cause,
  lsu_mem_ctrl_if.master      bus
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(LANES);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_e state_q, state_d;

  logic              op, ex_store, trap;
  logic [LANES-1:0]  ex_be, ex_wmask;
  logic [DATA_W-1:0] ex_wdata_sh;
  logic              ex_misaligned;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  wmask_q, be_q;
  logic              wen_q, killed_q;

  logic [DATA_W-1:0] rdata_q;
  logic [LANES-1:0]  be_out_q;
  logic              fault_q;
  logic [3:0]        cause_q;

  lsu_mem_ctrl_strb_gen #(.DATA_W(DATA_W)) u_strb_gen (
    .size        (lsu_size_e'(ex_size)),
    .offset      (ex_addr[OFF_W-1:0]),
    .wdata       (ex_wdata),
    .byte_enable (ex_be),
    .wmask       (ex_wmask),
    .wdata_sh    (ex_wdata_sh),
    .misaligned  (ex_misaligned)
  );

  // A load+store encoding is resolved as a load.
  assign op       = ex_valid && (ex_mem_read || ex_mem_write) && !flush;
  assign ex_store = ex_mem_write && !ex_mem_read;
  assign trap     = TRAP_EN && ex_misaligned;

  always_ff @(posedge clk) begin
    if (rst) state_q <= LSU_ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    lsu_done            = 1'b0;
    lsu_fault           = 1'b0;
    lsu_fault_cause     = '0;
    bus.bus_req_valid   = 1'b0;
    bus.bus_req_addr    = '0;
    bus.bus_req_wen     = 1'b0;
    bus.bus_req_wdata   = '0;
    bus.bus_req_wmask   = '0;

    unique case (state_q)
      LSU_ST_IDLE: if (op) state_d = trap ? LSU_ST_DONE : LSU_ST_REQ;
      LSU_ST_REQ: begin
        bus.bus_req_valid = 1'b1;
        bus.bus_req_addr  = addr_q;
        bus.bus_req_wen   = wen_q;
        bus.bus_req_wdata = wdata_q;
        bus.bus_req_wmask = wmask_q;
        if (bus.bus_req_ready) state_d = LSU_ST_WAIT;
      end
      LSU_ST_WAIT: if (bus.bus_resp_valid) state_d = LSU_ST_DONE;
      LSU_ST_DONE: begin
        lsu_done        = !killed_q;
        lsu_fault       = !killed_q && fault_q;
        lsu_fault_cause = killed_q ? 4'd0 : cause_q;
        state_d         = LSU_ST_IDLE;
      end
      default: state_d = LSU_ST_IDLE;
    endcase

    // The stalled instruction retires in the cycle lsu_done is seen.
    mem_stall = op && !lsu_done;
  end

  assign lsu_rdata       = rdata_q;
  assign lsu_byte_enable = be_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      be_q     <= '0;
      wen_q    <= 1'b0;
      killed_q <= 1'b0;
      rdata_q  <= '0;
      be_out_q <= '0;
      fault_q  <= 1'b0;
      cause_q  <= '0;
    end else begin
      unique case (state_q)
        LSU_ST_IDLE: begin
          killed_q <= 1'b0;
          if (op) begin
            addr_q  <= {ex_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata_q <= ex_wdata_sh;
            wmask_q <= ex_wmask;
            be_q    <= ex_be;
            wen_q   <= ex_store;
            fault_q <= trap;
            cause_q <= trap ? lsu_cause(ex_store, 1'b1) : 4'd0;
            if (trap) be_out_q <= ex_be;
          end
        end
        LSU_ST_REQ: if (flush) killed_q <= 1'b1;
        LSU_ST_WAIT: begin
          if (flush) killed_q <= 1'b1;
          // A flush arriving with the response already kills that response.
          if (bus.bus_resp_valid && !(killed_q || flush)) begin
            rdata_q  <= bus.bus_resp_err ? '0 : bus.bus_resp_rdata;
            be_out_q <= be_q;
            fault_q  <= bus.bus_resp_err;
            cause_q  <= bus.bus_resp_err ? lsu_cause(wen_q, 1'b0) : 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus randomized loads/stores
// against a transaction-level model of the sequencer and its bus.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, flush;
  logic [63:0] ex_addr, ex_wdata;
  logic [1:0]  ex_size;
  logic        mem_stall, lsu_done, lsu_fault;
  logic [63:0] lsu_rdata;
  logic [7:0]  lsu_byte_enable;
  logic [3:0]  lsu_fault_cause;

  lsu_mem_ctrl_if bus_if ();

  lsu_mem_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_addr         (ex_addr),
    .ex_wdata        (ex_wdata),
    .ex_size         (ex_size),
    .flush           (flush),
    .mem_stall       (mem_stall),
    .lsu_done        (lsu_done),
    .lsu_rdata       (lsu_rdata),
    .lsu_byte_enable (lsu_byte_enable),
    .lsu_fault       (lsu_fault),
    .lsu_fault_cause (lsu_fault_cause),
    .bus             (bus_if)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Architectural state the model tracks: last delivered load word and size mask.
  logic [63:0] cur_rdata = '0;
  logic [7:0]  cur_be    = '0;

  // Observations from the most recent transaction, pinned against literals.
  logic [63:0] seen_addr, seen_wdata, seen_rdata;
  logic [7:0]  seen_wmask, seen_be;
  logic        seen_wen, seen_req, seen_done, seen_fault;
  logic [3:0]  seen_cause;
  int          seen_req_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    int nb;
    nb = 1 << sz;
    return 8'((1 << nb) - 1);
  endfunction

  function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [1:0] sz);
    logic [7:0] m;
    int nb;
    nb = 1 << sz;
    for (int i = 0; i < 8; i++) m[i] = (i >= int'(off)) && (i < int'(off) + nb);
    return m;
  endfunction

  task automatic clear_seen();
    seen_req = 0; seen_done = 0; seen_fault = 0; seen_cause = '0; seen_req_cycles = 0;
    seen_addr = '0; seen_wdata = '0; seen_wmask = '0; seen_wen = 0; seen_rdata = '0; seen_be = '0;
  endtask

  // Compare all outputs in the current cycle, then advance to just after the next edge.
  task automatic check_cycle(input bit e_stall, input bit e_done, input bit e_fault,
                             input logic [3:0] e_cause, input bit e_req,
                             input logic [63:0] e_addr, input logic [63:0] e_wdata,
                             input logic [7:0] e_wmask, input bit e_wen);
    @(negedge clk);
    chk("mem_stall", mem_stall, e_stall);
    chk("lsu_done", lsu_done, e_done);
    chk("lsu_fault", lsu_fault, e_fault);
    chk("lsu_fault_cause", lsu_fault_cause, e_cause);
    chk("lsu_rdata", lsu_rdata, cur_rdata);
    chk("lsu_byte_enable", lsu_byte_enable, cur_be);
    chk("bus_req_valid", bus_if.bus_req_valid, e_req);
    if (e_req) begin
      chk("bus_req_addr", bus_if.bus_req_addr, e_addr);
      chk("bus_req_wdata", bus_if.bus_req_wdata, e_wdata);
      chk("bus_req_wmask", bus_if.bus_req_wmask, e_wmask);
      chk("bus_req_wen", bus_if.bus_req_wen, e_wen);
    end
    if (bus_if.bus_req_valid) begin
      seen_req_cycles++;
      if (!seen_req) begin
        seen_req = 1; seen_addr = bus_if.bus_req_addr; seen_wdata = bus_if.bus_req_wdata;
        seen_wmask = bus_if.bus_req_wmask; seen_wen = bus_if.bus_req_wen;
      end
    end
    if (lsu_done) begin
      seen_done = 1; seen_fault = lsu_fault; seen_cause = lsu_fault_cause;
      seen_rdata = lsu_rdata; seen_be = lsu_byte_enable;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      ex_valid = 0; ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
      flush = 1'($urandom);
      bus_if.bus_req_ready = 1'($urandom); bus_if.bus_resp_valid = 1'($urandom);
      bus_if.bus_resp_rdata = {$urandom, $urandom}; bus_if.bus_resp_err = 1'($urandom);
      check_cycle(0, 0, 0, 4'd0, 0, '0, '0, '0, 0);
    end
    flush = 0; bus_if.bus_resp_valid = 0; bus_if.bus_req_ready = 0;
  endtask

  // One MEM-stage instruction from presentation to retirement (or kill).
  task automatic run_op(input bit rd, input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [1:0] sz, input int rdy_lat, input int rsp_lat, input bit err,
                        input logic [63:0] rdat, input int flush_at);
    bit store, trap, accepted, responded, killed;
    int n, waited, off, nb;
    logic [7:0]  be, wm;
    logic [63:0] ea, ewd;
    store = wr && !rd;
    off   = int'(addr[2:0]);
    nb    = 1 << sz;
    be    = size_mask(sz);
    wm    = lane_mask(addr[2:0], sz);
    ea    = addr - 64'(off);
    ewd   = wd << (off * 8);
    trap  = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap  = (off % nb) != 0;
`endif
    clear_seen();
    ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_addr = addr; ex_wdata = wd; ex_size = sz;
    flush = 0;
    bus_if.bus_req_ready = 0; bus_if.bus_resp_valid = 1'($urandom);
    bus_if.bus_resp_rdata = {$urandom, $urandom}; bus_if.bus_resp_err = 1'($urandom);
    check_cycle(1, 0, 0, 4'd0, 0, '0, '0, '0, 0);

    if (trap) begin
      bus_if.bus_resp_valid = 0;
      cur_be = be;
      check_cycle(0, 1, 1, store ? 4'd6 : 4'd4, 0, '0, '0, '0, 0);
      ex_valid = 0;
      return;
    end

    accepted = 0; responded = 0; killed = 0; n = 1; waited = 0;
    while (!responded && n < 64) begin
      flush = (n == flush_at);
      if (!accepted) begin
        bus_if.bus_req_ready  = (n - 1 >= rdy_lat);
        bus_if.bus_resp_valid = !bus_if.bus_req_ready && ($urandom_range(0, 3) == 0);
        bus_if.bus_resp_rdata = {$urandom, $urandom};
        bus_if.bus_resp_err   = 1'($urandom);
      end else begin
        bus_if.bus_req_ready  = 1'($urandom);
        bus_if.bus_resp_valid = (waited >= rsp_lat);
        bus_if.bus_resp_rdata = bus_if.bus_resp_valid ? rdat : {$urandom, $urandom};
        bus_if.bus_resp_err   = bus_if.bus_resp_valid ? err : 1'($urandom);
      end
      check_cycle(ex_valid && !flush, 0, 0, 4'd0, !accepted, ea, ewd, wm, store);
      if (flush) killed = 1;
      if (killed) ex_valid = 0;
      flush = 0;
      if (!accepted) accepted = bus_if.bus_req_ready;
      else if (bus_if.bus_resp_valid) responded = 1;
      else waited++;
      n++;
    end
    if (!responded) chk("bus transaction completes", 0, 1);

    bus_if.bus_req_ready = 0; bus_if.bus_resp_valid = 1'($urandom);
    bus_if.bus_resp_rdata = {$urandom, $urandom}; bus_if.bus_resp_err = 1'($urandom);
    if (!killed) begin
      cur_rdata = err ? 64'd0 : rdat;
      cur_be    = be;
    end
    check_cycle(0, !killed, !killed && err, (!killed && err) ? (store ? 4'd7 : 4'd5) : 4'd0,
                0, '0, '0, '0, 0);
    ex_valid = 0; bus_if.bus_resp_valid = 0;
  endtask

  task automatic check_all_zero();
    @(negedge clk);
    chk("rst mem_stall", mem_stall, 0);
    chk("rst lsu_done", lsu_done, 0);
    chk("rst lsu_rdata", lsu_rdata, 0);
    chk("rst lsu_byte_enable", lsu_byte_enable, 0);
    chk("rst lsu_fault", lsu_fault, 0);
    chk("rst lsu_fault_cause", lsu_fault_cause, 0);
    chk("rst bus_req_valid", bus_if.bus_req_valid, 0);
    chk("rst bus_req_addr", bus_if.bus_req_addr, 0);
    chk("rst bus_req_wen", bus_if.bus_req_wen, 0);
    chk("rst bus_req_wdata", bus_if.bus_req_wdata, 0);
    chk("rst bus_req_wmask", bus_if.bus_req_wmask, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1; ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_addr = '0; ex_wdata = '0;
    ex_size = '0; flush = 0;
    bus_if.bus_req_ready = 0; bus_if.bus_resp_valid = 0; bus_if.bus_resp_rdata = '0;
    bus_if.bus_resp_err = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero();
    rst = 0;
    check_all_zero();

    // LB at 0x1003, response two cycles after acceptance.
    run_op(1, 0, 64'h1003, 64'h0, 2'd0, 0, 1, 0, 64'h11223344AA000000, -1);
    chk("LB addr", seen_addr, 64'h1000);
    chk("LB wmask", seen_wmask, 8'h08);
    chk("LB byte_enable", seen_be, 8'h01);
    chk("LB rdata", seen_rdata, 64'h11223344AA000000);
    idle(1);

    // SW with ready held low three cycles.
    run_op(0, 1, 64'h2004, 64'hDEADBEEF, 2'd2, 3, 0, 0, 64'h0, -1);
    chk("SW wdata", seen_wdata, 64'hDEADBEEF00000000);
    chk("SW wmask", seen_wmask, 8'hF0);
    chk("SW wen", seen_wen, 1);
    chk("SW req cycles", seen_req_cycles, 4);
    idle(1);

    // LD returning a bus error.
    run_op(1, 0, 64'h4000, 64'h0, 2'd3, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, -1);
    chk("LD err done", seen_done, 1);
    chk("LD err fault", seen_fault, 1);
    chk("LD err cause", seen_cause, 4'd5);
    chk("LD err rdata", seen_rdata, 64'h0);
    idle(1);

    // LW flushed in its first WAIT cycle, then a normal LW.
    run_op(1, 0, 64'h6008, 64'h0, 2'd2, 0, 2, 0, 64'h5555_6666_7777_8888, 2);
    chk("flushed LW done", seen_done, 0);
    run_op(1, 0, 64'h6010, 64'h0, 2'd2, 1, 0, 0, 64'h0123_4567_89AB_CDEF, -1);
    chk("LW after flush done", seen_done, 1);
    chk("LW after flush rdata", seen_rdata, 64'h0123_4567_89AB_CDEF);
    idle(1);

    // LH at 0x3001.
    run_op(1, 0, 64'h3001, 64'h0, 2'd1, 0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, -1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("LH misalign req", seen_req, 0);
    chk("LH misalign cause", seen_cause, 4'd4);
    chk("LH misalign done", seen_done, 1);
`else
    chk("LH wmask", seen_wmask, 8'h06);
    chk("LH addr", seen_addr, 64'h3000);
`endif
    idle(1);

    // Flush in IDLE: no request may follow.
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_addr = 64'h7000; ex_size = 2'd3; flush = 1;
    check_cycle(0, 0, 0, 4'd0, 0, '0, '0, '0, 0);
    ex_valid = 0; flush = 0;
    check_cycle(0, 0, 0, 4'd0, 0, '0, '0, '0, 0);

    // Reset while waiting for a response; the late response must be dropped.
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_addr = 64'h5000; ex_size = 2'd2;
    check_cycle(1, 0, 0, 4'd0, 0, '0, '0, '0, 0);
    bus_if.bus_req_ready = 1;
    check_cycle(1, 0, 0, 4'd0, 1, 64'h5000, 64'h0, 8'h0F, 0);
    bus_if.bus_req_ready = 0; rst = 1;
    check_cycle(1, 0, 0, 4'd0, 0, '0, '0, '0, 0);
    rst = 0; ex_valid = 0; cur_rdata = '0; cur_be = '0;
    bus_if.bus_resp_valid = 1; bus_if.bus_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    check_all_zero();
    bus_if.bus_resp_valid = 0;
    idle(2);
    run_op(1, 0, 64'h5008, 64'h0, 2'd3, 0, 0, 0, 64'h0F0F_0F0F_0F0F_0F0F, -1);
    chk("LD after reset rdata", seen_rdata, 64'h0F0F_0F0F_0F0F_0F0F);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      int kind, rl, sl, fa, nb;
      logic [1:0]  sz;
      logic [63:0] a;
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      nb   = 1 << sz;
      a    = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a = a & ~64'(nb - 1);
      rl   = $urandom_range(0, 3);
      sl   = $urandom_range(0, 3);
      fa   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, rl + sl + 3) : -1;
      run_op(kind != 1, kind != 0, a, {$urandom, $urandom}, sz, rl, sl,
             $urandom_range(0, 7) == 0, {$urandom, $urandom}, fa);
      idle($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
